// File: rtl/store_control_pkg.sv
// store_control_pkg: store opcodes and FSM state type shared by the store path
package store_control_pkg;
    localparam logic [5:0] OPCODE_SB = 6'h28;
    localparam logic [5:0] OPCODE_SH = 6'h29;
    localparam logic [5:0] OPCODE_SW = 6'h2B;
    typedef enum logic {IDLE, WRITE} state_t;
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: maps a store opcode, address lsbs and data to bus lanes and flags misalignment
module store_lane_align
    import store_control_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  lsb,
    input  logic [31:0] data,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        misaligned
);
    logic sb, sh, sw;
    assign sb = opcode == OPCODE_SB;
    assign sh = opcode == OPCODE_SH;
    assign sw = opcode == OPCODE_SW;
    assign misaligned = !(sb || (sh && !lsb[0]) || (sw && lsb == 2'b00));
    assign byteenable = sb ? 4'b0001 << lsb : sh ? (lsb[1] ? 4'b1100 : 4'b0011) : sw ? 4'b1111 : 4'b0000;
    assign writedata = sb ? {4{data[7:0]}} : sh ? {2{data[15:0]}} : data;
endmodule

// File: rtl/store_control.sv
// store_control: accepts SB/SH/SW requests and issues one Avalon-MM write per aligned store
module store_control
    import store_control_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              done,
    output logic              misaligned
);
    state_t state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0] be_q, be_c;
    logic [31:0] wdata_q, wdata_c;
    logic bad, accept, busy;
    store_lane_align u_align (
        .opcode(req_opcode),
        .lsb(req_addr[1:0]),
        .data(req_data),
        .byteenable(be_c),
        .writedata(wdata_c),
        .misaligned(bad)
    );
    assign busy = state == WRITE;
    assign req_ready = state == IDLE;
    assign accept = req_valid && req_ready;
    always_comb begin
        state_n = state;
        state_n = (accept && !bad) ? WRITE : (busy && !avm_waitrequest) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done <= 1'b0;
            misaligned <= 1'b0;
            addr_q <= '0;
            be_q <= 4'b0000;
            wdata_q <= 32'h0;
        end else begin
            state <= state_n;
            done <= busy && !avm_waitrequest;
            misaligned <= accept && bad;
            if (accept && !bad) begin
                addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                be_q <= be_c;
                wdata_q <= wdata_c;
            end
        end
    end
    // bus outputs read as zero whenever no write is in flight
    assign avm_write = busy;
    assign avm_address = busy ? addr_q : '0;
    assign avm_byteenable = busy ? be_q : 4'b0000;
    assign avm_writedata = busy ? wdata_q : 32'h0;
endmodule

// File: tb/tb_store_control.sv
// tb_store_control: directed stimulus with a per-cycle reference model and literal pins
module tb_store_control;
    logic        clk, rst_n, req_valid, req_ready, avm_write, avm_waitrequest, done, misaligned;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr, req_data, avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    int n_cmp = 0, n_bad = 0, n_done = 0, n_wcyc = 0;
    logic started = 1'b0;
    logic m_busy = 1'b0, m_done = 1'b0, m_mis = 1'b0;
    logic [31:0] m_addr = 0, m_wd = 0;
    logic [3:0]  m_be = 0;

    store_control #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_addr(req_addr), .req_data(req_data),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .done(done), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void lane(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                                 output logic ok, output logic [3:0] be, output logic [31:0] wd);
        int lsb;
        lsb = int'(a % 4);
        ok = 1'b0;
        be = 4'h0;
        wd = 32'h0;
        if (op == 6'h28) begin
            ok = 1'b1; be = 4'(1 << lsb); wd = d[7:0] * 32'h01010101;
        end else if (op == 6'h29 && lsb % 2 == 0) begin
            ok = 1'b1; be = 4'(3 << lsb); wd = d[15:0] * 32'h00010001;
        end else if (op == 6'h2B && lsb == 0) begin
            ok = 1'b1; be = 4'hF; wd = d;
        end
    endfunction

    always @(posedge clk) begin
        logic ok;
        logic [3:0] be;
        logic [31:0] wd;
        if (!rst_n) begin
            started = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_mis = 1'b0;
        end else begin
            m_done = m_busy && !avm_waitrequest;
            m_mis = 1'b0;
            if (m_busy) begin
                if (!avm_waitrequest) m_busy = 1'b0;
            end else if (req_valid) begin
                lane(req_opcode, req_addr, req_data, ok, be, wd);
                if (ok) begin
                    m_busy = 1'b1; m_addr = req_addr - (req_addr % 4); m_be = be; m_wd = wd;
                end else m_mis = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", {31'd0, req_ready}, {31'd0, !m_busy});
            chk("write", {31'd0, avm_write}, {31'd0, m_busy});
            chk("address", avm_address, m_busy ? m_addr : 32'h0);
            chk("byteenable", {28'd0, avm_byteenable}, {28'd0, m_busy ? m_be : 4'h0});
            chk("writedata", avm_writedata, m_busy ? m_wd : 32'h0);
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
            if (done) n_done++;
            if (avm_write) n_wcyc++;
        end
    end

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input logic w);
        req_valid = 1'b1; req_opcode = op; req_addr = a; req_data = d; avm_waitrequest = w;
    endtask

    task automatic do_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input int waits);
        int cnt;
        logic fin;
        cnt = 0;
        fin = 1'b0;
        drive(op, a, d, waits > 0);
        go;
        req_valid = 1'b0;
        for (int k = 0; k < 30 && !fin; k++) begin
            @(negedge clk);
            if (done || misaligned) fin = 1'b1;
            go;
            cnt++;
            if (cnt >= waits) avm_waitrequest = 1'b0;
        end
        chk("store_finished", {31'd0, fin}, 32'd1);
    endtask

    initial begin
        int d0, w0;
        rst_n = 1'b0; req_valid = 1'b0; req_opcode = 6'h0; req_addr = 32'h0; req_data = 32'h0;
        avm_waitrequest = 1'b0;
        go; go;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_write", {31'd0, avm_write}, 32'd0);
        chk("rst_be", {28'd0, avm_byteenable}, 32'd0);
        go;
        rst_n = 1'b1;
        go;
        drive(6'h28, 32'h1003, 32'h000000A5, 1'b0);
        go;
        req_valid = 1'b0;
        @(negedge clk);
        chk("sb_write", {31'd0, avm_write}, 32'd1);
        chk("sb_addr", avm_address, 32'h1000);
        chk("sb_be", {28'd0, avm_byteenable}, 32'h8);
        chk("sb_wd", avm_writedata, 32'hA5A5A5A5);
        go;
        @(negedge clk);
        chk("sb_done", {31'd0, done}, 32'd1);
        go;
        d0 = n_done;
        drive(6'h29, 32'h2002, 32'h1234BEEF, 1'b1);
        go;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sh_write", {31'd0, avm_write}, 32'd1);
            chk("sh_be", {28'd0, avm_byteenable}, 32'hC);
            chk("sh_wd", avm_writedata, 32'hBEEFBEEF);
            chk("sh_nodone", {31'd0, done}, 32'd0);
            go;
            if (i == 2) avm_waitrequest = 1'b0;
        end
        @(negedge clk);
        chk("sh_done", {31'd0, done}, 32'd1);
        go; go;
        @(negedge clk);
        chk("sh_one_done", n_done - d0, 32'd1);
        w0 = n_wcyc;
        drive(6'h2B, 32'h3001, 32'h0, 1'b0);
        go;
        req_valid = 1'b0;
        @(negedge clk);
        chk("sw_mis", {31'd0, misaligned}, 32'd1);
        chk("sw_ready", {31'd0, req_ready}, 32'd1);
        go;
        @(negedge clk);
        chk("sw_mis_pulse", {31'd0, misaligned}, 32'd0);
        chk("sw_no_write", n_wcyc - w0, 32'd0);
        go;
        drive(6'h2B, 32'h4000, 32'h11223344, 1'b0);
        go;
        drive(6'h28, 32'h4001, 32'h00000077, 1'b0);
        @(negedge clk);
        chk("b2b_be1", {28'd0, avm_byteenable}, 32'hF);
        chk("b2b_wd1", avm_writedata, 32'h11223344);
        go;
        @(negedge clk);
        chk("b2b_idle", {31'd0, avm_write}, 32'd0);
        chk("b2b_done1", {31'd0, done}, 32'd1);
        go;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_write2", {31'd0, avm_write}, 32'd1);
        chk("b2b_be2", {28'd0, avm_byteenable}, 32'h2);
        chk("b2b_wd2", avm_writedata, 32'h77777777);
        chk("b2b_addr2", avm_address, 32'h4000);
        go; go;
        d0 = n_done;
        drive(6'h2B, 32'h5000, 32'hDEADBEEF, 1'b1);
        go;
        drive(6'h2B, 32'h6000, 32'h12121212, 1'b1);
        @(negedge clk);
        chk("rw_write", {31'd0, avm_write}, 32'd1);
        rst_n = 1'b0;
        go;
        @(negedge clk);
        chk("rw_write_off", {31'd0, avm_write}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        go;
        req_valid = 1'b0; avm_waitrequest = 1'b0; rst_n = 1'b1;
        go; go;
        @(negedge clk);
        chk("rw_no_done", n_done - d0, 32'd0);
        chk("rw_idle", {31'd0, avm_write}, 32'd0);
        go;
        do_store(6'h28, 32'h10, 32'h12345678, 0);
        do_store(6'h28, 32'h11, 32'h9ABCDEF0, 1);
        do_store(6'h28, 32'h12, 32'h0000005A, 2);
        do_store(6'h29, 32'h20, 32'hCAFEF00D, 0);
        do_store(6'h29, 32'h21, 32'hCAFEF00D, 0);
        do_store(6'h29, 32'h22, 32'h00004321, 1);
        do_store(6'h2B, 32'h30, 32'h89ABCDEF, 2);
        do_store(6'h2B, 32'h32, 32'h89ABCDEF, 0);
        do_store(6'h23, 32'h40, 32'h11111111, 0);
        go; go;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
